fetch_prefetch_buffer: RTL and testbench

Instruction-fetch front end that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC and issues in-order requests to a fixed-latency instruction memory. Returned words are buffered with their PC and PC+4 in a small FIFO, so IF/ID stalls and branch/jalr redirects do not lose or replay fetches. On a redirect it flushes both queued and in-flight instructions.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_prefetch_buffer_if.sv | 46 ++++
 rtl/sync_fifo.sv | 53 +++++
 rtl/fetch_prefetch_buffer.sv | 107 ++++++++++
 tb/tb_fetch_prefetch_buffer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared widths and the buffered fetch entry type for the fetch front end.
package fetch_pkg;

    localparam int XLEN = 64;
    localparam int ILEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEF = '0;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
        logic [XLEN-1:0] pc4;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return pc + XLEN'(4);
    endfunction

endpackage

// File: rtl/fetch_prefetch_buffer_if.sv
// Redirect, IF/ID dequeue, instruction memory and head-entry signals
// of the fetch prefetch buffer.
interface fetch_prefetch_buffer_if;
    import fetch_pkg::*;

    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            deq;
    logic            mem_req;
    logic [XLEN-1:0] mem_addr;
    logic            mem_rvalid;
    logic [ILEN-1:0] mem_rdata;
    logic            out_valid;
    logic [XLEN-1:0] out_pc;
    logic [ILEN-1:0] out_inst;
    logic [XLEN-1:0] out_pc4;

    modport master (
        input  redirect,
        input  redirect_pc,
        input  deq,
        input  mem_rvalid,
        input  mem_rdata,
        output mem_req,
        output mem_addr,
        output out_valid,
        output out_pc,
        output out_inst,
        output out_pc4
    );

    modport slave (
        output redirect,
        output redirect_pc,
        output deq,
        output mem_rvalid,
        output mem_rdata,
        input  mem_req,
        input  mem_addr,
        input  out_valid,
        input  out_pc,
        input  out_inst,
        input  out_pc4
    );

endinterface

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush and occupancy count; any depth >= 2.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    // A full FIFO still accepts a push when the head leaves this cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wrap_inc(wr_ptr);
            if (do_pop)  rd_ptr <= wrap_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/fetch_prefetch_buffer.sv
// Fetch PC owner and prefetch buffer feeding IF/ID; flushes on redirect.
// Define PREFETCH_BYPASS_EN to forward a response into an empty buffer same-cycle.
module fetch_prefetch_buffer
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter int              MEM_LAT  = 2,
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEF
) (
    input logic                     clk,
    input logic                     rst,
    fetch_prefetch_buffer_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int FD = MEM_LAT + 1;
    localparam int IW = $clog2(FD + 1);

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] rsp_pc;
    logic [IW-1:0]   inflight;
    logic [IW-1:0]   discard;
    logic [CW-1:0]   count;
    logic            empty;
    logic            credit;
    logic            rsp_ok;
    logic            q_push;
    logic            q_pop;
    logic            out_valid;
    fetch_entry_t    rsp_entry;
    fetch_entry_t    q_head;
    fetch_entry_t    head;

    // Stale in-flight fetches still hold credit until they return.
    assign empty        = (count == '0);
    assign credit       = (int'(count) + int'(inflight)) < DEPTH;
    assign bus.mem_req  = !rst && !bus.redirect && credit;
    assign bus.mem_addr = rst ? '0 : fetch_pc;

    assign rsp_ok    = !rst && bus.mem_rvalid && (discard == '0);
    assign rsp_entry = '{pc: rsp_pc, inst: bus.mem_rdata, pc4: next_pc(rsp_pc)};
    assign q_pop     = bus.deq && !empty && !bus.redirect;

`ifdef PREFETCH_BYPASS_EN
    logic bypass;

    assign bypass    = empty && rsp_ok;
    assign q_push    = rsp_ok && !bus.redirect && !(bypass && bus.deq);
    assign out_valid = !rst && (!empty || rsp_ok);
    assign head      = bypass ? rsp_entry : q_head;
`else
    assign q_push    = rsp_ok && !bus.redirect;
    assign out_valid = !rst && !empty;
    assign head      = q_head;
`endif

    assign bus.out_valid = out_valid;
    assign bus.out_pc    = out_valid ? head.pc   : '0;
    assign bus.out_inst  = out_valid ? head.inst : '0;
    assign bus.out_pc4   = out_valid ? head.pc4  : '0;

    // Every fetch still outstanding after a redirect cycle is stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            discard  <= '0;
        end else if (bus.redirect) begin
            fetch_pc <= bus.redirect_pc;
            discard  <= inflight - IW'(bus.mem_rvalid);
        end else begin
            if (bus.mem_req) begin
                fetch_pc <= next_pc(fetch_pc);
            end
            if (bus.mem_rvalid && (discard != '0)) begin
                discard <= discard - IW'(1);
            end
        end
    end

    sync_fifo #(
        .WIDTH (XLEN),
        .DEPTH (FD)
    ) u_pc_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (1'b0),
        .push  (bus.mem_req),
        .pop   (bus.mem_rvalid && !rst),
        .din   (fetch_pc),
        .dout  (rsp_pc),
        .count (inflight)
    );

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_entry_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.redirect),
        .push  (q_push),
        .pop   (q_pop),
        .din   (rsp_entry),
        .dout  (q_head),
        .count (count)
    );

endmodule

// File: tb/tb_fetch_prefetch_buffer.sv
// Bench for fetch_prefetch_buffer: queue-level reference model plus
// directed reset, stall, redirect and latency scenarios.
module tb_fetch_prefetch_buffer;
    import fetch_pkg::*;

    localparam int DEPTH   = 4;
    localparam int MEM_LAT = 2;
`ifdef PREFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [63:0] pc;
        bit          stale;
    } fly_t;

    typedef struct {
        longint      due;
        logic [63:0] addr;
    } mreq_t;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_chk;
    int   rel;
    int   mark;
    int   bad;

    fly_t        fly[$];
    logic [63:0] bq[$];
    logic [63:0] dlog[$];
    logic [63:0] m_fetch;
    logic [63:0] m_pc;
    logic        m_req;
    logic        m_valid;
    logic        m_live;
    mreq_t       mq[$];
    longint      mcyc;

    fetch_prefetch_buffer_if bus();

    fetch_prefetch_buffer #(
        .DEPTH    (DEPTH),
        .MEM_LAT  (MEM_LAT),
        .RESET_PC (64'd0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [63:0] a);
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h0000_0013;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    endtask

    // Fixed-latency instruction memory: response exactly MEM_LAT cycles later.
    initial begin
        mcyc = 0;
        forever begin
            @(posedge clk);
            #1;
            mcyc++;
            if (mq.size() > 0 && mq[0].due == mcyc) begin
                bus.mem_rvalid = 1'b1;
                bus.mem_rdata  = memw(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                bus.mem_rvalid = 1'b0;
                bus.mem_rdata  = $urandom;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst) mq.delete();
        else if (bus.mem_req) mq.push_back('{mcyc + MEM_LAT, bus.mem_addr});
    end

    // Reference model: fetch sequence, in-flight list, and buffered PCs.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("rst_outs", bus.mem_addr | bus.out_pc | bus.out_pc4 |
                64'(bus.out_inst) | 64'({bus.mem_req, bus.out_valid}), 64'd0);
            m_fetch = 64'd0;
            fly.delete();
            bq.delete();
        end else begin
            m_live  = bus.mem_rvalid && fly.size() > 0 && !fly[0].stale;
            m_req   = !bus.redirect && (bq.size() + fly.size() < DEPTH);
            chk("mem_req", bus.mem_req, m_req);
            if (m_req) chk("mem_addr", bus.mem_addr, m_fetch);
            m_valid = bq.size() > 0 || (BYP && m_live);
            m_pc    = bq.size() > 0 ? bq[0] : (fly.size() > 0 ? fly[0].pc : 64'd0);
            chk("out_valid", bus.out_valid, m_valid);
            if (m_valid) begin
                chk("out_pc", bus.out_pc, m_pc);
                chk("out_inst", 64'(bus.out_inst), 64'(memw(m_pc)));
                chk("out_pc4", bus.out_pc4, m_pc + 64'd4);
                if (bus.deq && !bus.redirect) dlog.push_back(m_pc);
            end
            if (bus.mem_rvalid && fly.size() > 0) begin
                if (m_live && !bus.redirect) bq.push_back(fly[0].pc);
                void'(fly.pop_front());
            end
            if (bus.redirect) begin
                bq.delete();
                foreach (fly[i]) fly[i].stale = 1'b1;
                m_fetch = bus.redirect_pc;
            end else begin
                if (m_valid && bus.deq) void'(bq.pop_front());
                if (m_req) begin
                    fly.push_back('{m_fetch, 1'b0});
                    m_fetch = m_fetch + 64'd4;
                end
            end
        end
    end

    task automatic cyc(input logic r, input logic [63:0] rpc, input logic d);
        @(posedge clk);
        #1;
        rst             = 1'b0;
        bus.redirect    = r;
        bus.redirect_pc = rpc;
        bus.deq         = d;
        rel++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst          = 1'b1;
        bus.redirect = 1'b0;
        bus.deq      = 1'b0;
        @(negedge clk);
        chk("rst_req", bus.mem_req, 0);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_addr", bus.mem_addr, 0);
        @(posedge clk);
        @(negedge clk);
        rel = -1;
    endtask

    function automatic logic [63:0] dl(input int i);
        return (dlog.size() > i) ? dlog[i] : '1;
    endfunction

    initial begin
        n_pass = 0;
        n_chk  = 0;
        rst             = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = '0;
        bus.deq         = 1'b0;
        bus.mem_rvalid  = 1'b0;
        bus.mem_rdata   = '0;

        // Streaming with IF/ID always accepting; first-word latency.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, 64'd0, 1'b1);
            if (rel <= 2) chk("t1_addr", bus.mem_addr, 64'(rel) * 64'd4);
            if (rel == 2) chk("t6_lat_t", bus.out_valid, BYP);
            if (rel == 3) begin
                chk("t6_lat_t1", bus.out_valid, 1);
                chk("t1_pc", bus.out_pc, BYP ? 64'h4 : 64'h0);
                chk("t1_pc4", bus.out_pc4, BYP ? 64'h8 : 64'h4);
            end
        end

        // IF/ID stalled: buffer fills to DEPTH, then drains in order.
        do_reset();
        for (int i = 0; i < 15; i++) begin
            cyc(1'b0, 64'd0, rel >= 9);
            if (rel == 3) chk("t2_req_on", bus.mem_req, 1);
            if (rel == 4 || rel == 6 || rel == 9) chk("t2_credit", bus.mem_req, 0);
            if (rel == 6) chk("t2_head", bus.out_pc, 64'h0);
            if (rel >= 10) chk("t2_order", bus.out_pc, 64'(rel - 10) * 64'd4);
        end

        // Redirect while words are queued and fetches are in flight.
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1'b0, 64'd0, 1'b0);
        cyc(1'b1, 64'h100, 1'b0);
        mark = dlog.size();
        cyc(1'b0, 64'd0, 1'b1);
        chk("t3_flushed", bus.out_valid, 0);
        chk("t3_refetch", bus.mem_addr, 64'h100);
        for (int i = 0; i < 10; i++) cyc(1'b0, 64'd0, 1'b1);
        chk("t3_first", dl(mark), 64'h100);
        bad = 0;
        for (int i = mark; i < dlog.size(); i++) if (dlog[i] < 64'h100) bad++;
        chk("t3_no_stale", 64'(bad), 0);

        // Redirect coinciding with deq and an arriving response.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b0, 64'd0, 1'b1);
        cyc(1'b1, 64'h400, 1'b1);
        mark = dlog.size();
        cyc(1'b0, 64'd0, 1'b1);
        chk("t4_empty", bus.out_valid, 0);
        chk("t4_req", bus.mem_req, 1);
        chk("t4_addr", bus.mem_addr, 64'h400);
        for (int i = 0; i < 8; i++) cyc(1'b0, 64'd0, 1'b1);
        chk("t4_first", dl(mark), 64'h400);
        chk("t4_second", dl(mark + 1), 64'h404);

        // Back-to-back redirects: only the second target stream appears.
        do_reset();
        for (int i = 0; i < 5; i++) cyc(1'b0, 64'd0, 1'b1);
        cyc(1'b1, 64'h200, 1'b1);
        mark = dlog.size();
        cyc(1'b1, 64'h300, 1'b1);
        chk("t5_no_req", bus.mem_req, 0);
        cyc(1'b0, 64'd0, 1'b1);
        chk("t5_addr", bus.mem_addr, 64'h300);
        for (int i = 0; i < 9; i++) cyc(1'b0, 64'd0, 1'b1);
        chk("t5_first", dl(mark), 64'h300);
        chk("t5_second", dl(mark + 1), 64'h304);
        bad = 0;
        for (int i = mark; i < dlog.size(); i++) if (dlog[i] < 64'h300) bad++;
        chk("t5_no_stale", 64'(bad), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
